// File: rtl/cpu_pkg.sv
// Shared types and constants for the 3-bit-opcode, 4-bit-register pipelined core.
package cpu_pkg;

    localparam int OPCODE_W   = 3;
    localparam int REG_ADDR_W = 4;

    localparam logic [OPCODE_W-1:0] OP_JR = 3'b111;

    // Bubble encoding; also decodes as opcode 3'b000.
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready handshake between the fetch stage and imem.
interface fetch_stage_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
);
    logic               req;
    logic [PC_W-1:0]    addr;
    logic               ready;
    logic [INSTR_W-1:0] rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush to bubble, hold on stall, load on accept,
// and a registered opcode that reads 3'b000 whenever the stage holds a bubble.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int PC_W    = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic                hold,
    input  logic                load,
    input  logic [INSTR_W-1:0]  instr_in,
    input  logic [PC_W-1:0]     pc_in,
    output logic                valid,
    output logic [INSTR_W-1:0]  instr,
    output logic [PC_W-1:0]     pc,
    output logic [OPCODE_W-1:0] opcode
);

    logic                valid_s;
    logic [INSTR_W-1:0]  instr_s;
    logic [PC_W-1:0]     pc_s;
    logic [OPCODE_W-1:0] opcode_s;

    // Next-value selection: flush beats hold beats load.
    always_comb begin
        valid_s  = valid;
        instr_s  = instr;
        pc_s     = pc;
        opcode_s = opcode;
        if (flush) begin
            valid_s  = 1'b0;
            instr_s  = INSTR_W'(NOP_INSTR);
            pc_s     = '0;
            opcode_s = 3'b000;
        end else if (hold) begin
            valid_s  = valid;
            instr_s  = instr;
            pc_s     = pc;
            opcode_s = opcode;
        end else if (load) begin
            valid_s  = 1'b1;
            instr_s  = instr_in;
            pc_s     = pc_in;
            opcode_s = instr_in[INSTR_W-1 -: OPCODE_W];
        end else begin
            valid_s  = valid;
            instr_s  = instr;
            pc_s     = pc;
            opcode_s = opcode;
        end
    end

    // IF/ID state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid  <= 1'b0;
            instr  <= INSTR_W'(NOP_INSTR);
            pc     <= '0;
            opcode <= 3'b000;
        end else begin
            valid  <= valid_s;
            instr  <= instr_s;
            pc     <= pc_s;
            opcode <= opcode_s;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, BOOT/RUN sequencing, imem handshake and the IF/ID register.
// Optional stall/bubble performance counters under `FETCH_PERF_CNT_EN.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int               INSTR_W  = 16,
    parameter int               PC_W     = 8,
    parameter logic [PC_W-1:0]  RESET_PC = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [PC_W-1:0]      redirect_pc,
    fetch_stage_if.master        imem,
    output logic                 if_id_valid,
    output logic [INSTR_W-1:0]   if_id_instr,
    output logic [PC_W-1:0]      if_id_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]          perf_stall_cnt,
    output logic [15:0]          perf_bubble_cnt,
`endif
    output logic [OPCODE_W-1:0]  id_opcode
);

    fetch_state_t    state_r;
    fetch_state_t    state_s;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pc_s;
    logic            run_s;
    logic            accept_s;
    logic            flush_s;
    logic            hold_s;

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= BOOT;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state and stage control decode.
    always_comb begin
        state_s  = state_r;
        run_s    = 1'b0;
        case (state_r)
            BOOT:    begin state_s = RUN; run_s = 1'b0; end
            RUN:     begin state_s = RUN; run_s = 1'b1; end
            default: begin state_s = BOOT; run_s = 1'b0; end
        endcase
        accept_s = run_s & imem.ready & ~stall & ~redirect_valid;
        hold_s   = run_s & stall & ~redirect_valid;
        // BOOT, redirect and memory wait states all load a bubble.
        flush_s  = ~run_s | redirect_valid | (~stall & ~accept_s);
    end

    assign imem.req  = run_s;
    assign imem.addr = pc_r;

    // Next PC: redirect wins, stall freezes, accept advances with wrap.
    always_comb begin
        pc_s = pc_r;
        if (run_s && redirect_valid) begin
            pc_s = redirect_pc;
        end else if (accept_s) begin
            pc_s = pc_r + PC_W'(1);
        end else begin
            pc_s = pc_r;
        end
    end

    // PC register.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_s;
        end
    end

    if_id_reg #(
        .INSTR_W (INSTR_W),
        .PC_W    (PC_W)
    ) u_if_id_reg (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush_s),
        .hold     (hold_s),
        .load     (accept_s),
        .instr_in (imem.rdata),
        .pc_in    (pc_r),
        .valid    (if_id_valid),
        .instr    (if_id_instr),
        .pc       (if_id_pc),
        .opcode   (id_opcode)
    );

`ifdef FETCH_PERF_CNT_EN
    // Saturating counters of effective stall cycles and bubble loads in RUN.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_stall_cnt  <= 16'h0000;
            perf_bubble_cnt <= 16'h0000;
        end else begin
            if (hold_s && (perf_stall_cnt != 16'hFFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 16'h0001;
            end else begin
                perf_stall_cnt <= perf_stall_cnt;
            end
            if (run_s && flush_s && (perf_bubble_cnt != 16'hFFFF)) begin
                perf_bubble_cnt <= perf_bubble_cnt + 16'h0001;
            end else begin
                perf_bubble_cnt <= perf_bubble_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; imem model returns data_base + addr.
module tb_fetch_stage;
    import cpu_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic        if_id_valid;
    logic [15:0] if_id_instr;
    logic [7:0]  if_id_pc;
    logic [2:0]  id_opcode;
    logic [15:0] data_base = 16'h1000;
    logic        mem_ready = 1'b1;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_stall_cnt;
    logic [15:0] perf_bubble_cnt;
`endif
    int errors = 0;
    int checks = 0;

    fetch_stage_if #(.PC_W(8), .INSTR_W(16)) imem ();

    assign imem.ready = mem_ready;
    assign imem.rdata = data_base + {8'h00, imem.addr};

    fetch_stage #(.INSTR_W(16), .PC_W(8), .RESET_PC(8'h00)) dut (
        .clock           (clock),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem            (imem),
        .if_id_valid     (if_id_valid),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
`ifdef FETCH_PERF_CNT_EN
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_bubble_cnt (perf_bubble_cnt),
`endif
        .id_opcode       (id_opcode)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; mem_ready = 1'b1;
        tick(); tick();
        checks += 6;
        if (imem.req !== 1'b0)      begin errors++; $display("FAIL reset_req got %0b want 0", imem.req); end
        if (imem.addr !== 8'h00)    begin errors++; $display("FAIL reset_addr got %0h want 00", imem.addr); end
        if (if_id_valid !== 1'b0)   begin errors++; $display("FAIL reset_valid got %0b want 0", if_id_valid); end
        if (if_id_instr !== 16'h0)  begin errors++; $display("FAIL reset_instr got %0h want 0000", if_id_instr); end
        if (if_id_pc !== 8'h00)     begin errors++; $display("FAIL reset_pc got %0h want 00", if_id_pc); end
        if (id_opcode !== 3'b000)   begin errors++; $display("FAIL reset_opcode got %0b want 000", id_opcode); end
        reset = 1'b0;
        tick();
        checks += 2;
        if (imem.req !== 1'b1)      begin errors++; $display("FAIL boot_req got %0b want 1", imem.req); end
        if (if_id_valid !== 1'b0)   begin errors++; $display("FAIL boot_valid got %0b want 0", if_id_valid); end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks += 3;
            if (if_id_pc !== 8'(i))                begin errors++; $display("FAIL seq_pc got %0h want %0h", if_id_pc, i); end
            if (if_id_valid !== 1'b1)              begin errors++; $display("FAIL seq_valid got %0b want 1", if_id_valid); end
            if (if_id_instr !== 16'h1000 + 16'(i)) begin errors++; $display("FAIL seq_instr got %0h want %0h", if_id_instr, 16'h1000 + 16'(i)); end
        end
        tick();
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks += 3;
            if (if_id_pc !== 8'h04)   begin errors++; $display("FAIL stall_ifid_pc got %0h want 04", if_id_pc); end
            if (imem.addr !== 8'h05)  begin errors++; $display("FAIL stall_addr got %0h want 05", imem.addr); end
            if (if_id_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %0b want 1", if_id_valid); end
        end
        stall = 1'b0;
        tick();
        checks += 2;
        if (if_id_pc !== 8'h05)       begin errors++; $display("FAIL unstall_pc got %0h want 05", if_id_pc); end
        if (if_id_instr !== 16'h1005) begin errors++; $display("FAIL unstall_instr got %0h want 1005", if_id_instr); end
        tick();
        checks += 1;
        if (if_id_pc !== 8'h06)       begin errors++; $display("FAIL unstall_next got %0h want 06", if_id_pc); end
    endtask

    task automatic test_redirect();
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h40;
        tick();
        checks += 4;
        if (if_id_valid !== 1'b0)   begin errors++; $display("FAIL redir_valid got %0b want 0", if_id_valid); end
        if (id_opcode !== 3'b000)   begin errors++; $display("FAIL redir_opcode got %0b want 000", id_opcode); end
        if (imem.addr !== 8'h40)    begin errors++; $display("FAIL redir_addr got %0h want 40", imem.addr); end
        if (if_id_instr !== 16'h0)  begin errors++; $display("FAIL redir_instr got %0h want 0000", if_id_instr); end
        stall = 1'b0; redirect_valid = 1'b0;
        tick();
        checks += 2;
        if (if_id_pc !== 8'h40)     begin errors++; $display("FAIL redir_target got %0h want 40", if_id_pc); end
        if (if_id_valid !== 1'b1)   begin errors++; $display("FAIL redir_target_valid got %0b want 1", if_id_valid); end
    endtask

    task automatic test_wait();
        redirect_valid = 1'b1; redirect_pc = 8'h09;
        tick();
        redirect_valid = 1'b0; mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks += 2;
            if (if_id_valid !== 1'b0) begin errors++; $display("FAIL wait_valid got %0b want 0", if_id_valid); end
            if (imem.addr !== 8'h09)  begin errors++; $display("FAIL wait_addr got %0h want 09", imem.addr); end
        end
        mem_ready = 1'b1;
        tick();
        checks += 2;
        if (if_id_pc !== 8'h09)       begin errors++; $display("FAIL wait_resume_pc got %0h want 09", if_id_pc); end
        if (if_id_instr !== 16'h1009) begin errors++; $display("FAIL wait_resume_instr got %0h want 1009", if_id_instr); end
    endtask

    task automatic test_wrap();
        data_base = 16'hE000;
        redirect_valid = 1'b1; redirect_pc = 8'hFE;
        tick();
        redirect_valid = 1'b0;
        tick();
        checks += 2;
        if (if_id_pc !== 8'hFE)       begin errors++; $display("FAIL wrap_fe got %0h want fe", if_id_pc); end
        if (id_opcode !== OP_JR)      begin errors++; $display("FAIL wrap_opcode got %0b want 111", id_opcode); end
        tick();
        checks += 2;
        if (if_id_pc !== 8'hFF)       begin errors++; $display("FAIL wrap_ff got %0h want ff", if_id_pc); end
        if (imem.addr !== 8'h00)      begin errors++; $display("FAIL wrap_addr got %0h want 00", imem.addr); end
        tick();
        checks += 1;
        if (if_id_instr !== 16'hE000) begin errors++; $display("FAIL wrap_instr got %0h want e000", if_id_instr); end
        mem_ready = 1'b0;
        tick();
        checks += 1;
        if (id_opcode !== 3'b000)     begin errors++; $display("FAIL bubble_mask got %0b want 000", id_opcode); end
        mem_ready = 1'b1; data_base = 16'h1000;
    endtask

    task automatic test_reset_mid();
        reset = 1'b1; stall = 1'b1;
        tick();
        checks += 3;
        if (imem.req !== 1'b0)      begin errors++; $display("FAIL midreset_req got %0b want 0", imem.req); end
        if (imem.addr !== 8'h00)    begin errors++; $display("FAIL midreset_addr got %0h want 00", imem.addr); end
        if (if_id_valid !== 1'b0)   begin errors++; $display("FAIL midreset_valid got %0b want 0", if_id_valid); end
        reset = 1'b0; stall = 1'b0;
        tick();
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        checks += 2;
        if (perf_stall_cnt !== 16'h0)  begin errors++; $display("FAIL perf_init_stall got %0d want 0", perf_stall_cnt); end
        if (perf_bubble_cnt !== 16'h0) begin errors++; $display("FAIL perf_init_bubble got %0d want 0", perf_bubble_cnt); end
        stall = 1'b1;
        tick(); tick(); tick();
        stall = 1'b0; mem_ready = 1'b0;
        tick(); tick();
        mem_ready = 1'b1;
        tick();
        checks += 2;
        if (perf_stall_cnt !== 16'd3)  begin errors++; $display("FAIL perf_stall got %0d want 3", perf_stall_cnt); end
        if (perf_bubble_cnt !== 16'd2) begin errors++; $display("FAIL perf_bubble got %0d want 2", perf_bubble_cnt); end
        reset = 1'b1;
        tick();
        checks += 2;
        if (perf_stall_cnt !== 16'h0)  begin errors++; $display("FAIL perf_clr_stall got %0d want 0", perf_stall_cnt); end
        if (perf_bubble_cnt !== 16'h0) begin errors++; $display("FAIL perf_clr_bubble got %0d want 0", perf_bubble_cnt); end
        reset = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_wait();
        test_wrap();
        test_reset_mid();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 3-bit-opcode, 4-bit-register pipelined core.
- Holds the PC, issues requests to instruction memory with a ready handshake, and latches fetched words into IF/ID.
- Consumes `stall` from the hazard detector to freeze PC and IF/ID. Consumes the jump redirect from EX to flush.
- Drives the decoded opcode of the ID-stage instruction back to the hazard detector's opcode input.

Parameters:
- INSTR_W, 16, instruction width; opcode is bits [INSTR_W-1 -: 3].
- PC_W, 8, PC/instruction-address width (word addressed).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- stall  in  1  hazard stall; freeze PC and IF/ID
- redirect_valid  in  1  taken jump resolved in EX; flush and load redirect_pc
- redirect_pc  in  PC_W  jump target
- imem_req  out  1  fetch request valid
- imem_addr  out  PC_W  fetch address (= pc)
- imem_ready  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  INSTR_W  fetched instruction, valid when imem_req & imem_ready
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_instr  out  INSTR_W  IF/ID instruction (NOP_INSTR when bubble)
- if_id_pc  out  PC_W  PC of if_id_instr
- id_opcode  out  3  if_id_instr opcode when if_id_valid, else 3'b000

Behaviour:
- FSM states: BOOT, RUN.
  - Reset → BOOT.
  - BOOT → RUN unconditionally after 1 cycle.
  - RUN stays RUN until reset.
- Reset values:
  - pc=RESET_PC, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0.
  - imem_req=0 (BOOT), id_opcode=0.
- imem_req = (state==RUN), combinational. imem_addr = pc, combinational.
- accept = imem_req & imem_ready & ~stall & ~redirect_valid.
- Per-cycle priority in RUN (registered, take effect next edge):
  1. redirect_valid:
     - pc<=redirect_pc.
     - IF/ID <= bubble (valid=0, instr=NOP_INSTR, pc=0).
     - Wins over stall and imem_ready; any returned word is discarded.
  2. stall:
     - pc, if_id_* hold.
     - Returned word is discarded; the same address is re-requested next cycle.
  3. accept:
     - if_id_instr<=imem_rdata, if_id_pc<=pc, if_id_valid<=1.
     - pc<=pc+1 modulo 2^PC_W (0xFF wraps to 0x00).
  4. otherwise (memory wait state): IF/ID <= bubble; pc holds.
- In BOOT, stall and redirect are ignored and IF/ID stays at bubble.
- Latency:
  - Word accepted at edge N appears on if_id_* and id_opcode after edge N.
  - Sustained throughput is 1 instruction/cycle with imem_ready=1 and no stall.
- id_opcode is masked to 3'b000 on a bubble, so a bubble never asserts the hazard detector's jump-register condition (opcode 3'b111).
- Reset asserted mid-operation: all state returns to reset values at the next edge; the in-flight fetch is abandoned.
- No combinational path from imem_rdata to any output other than through IF/ID.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_stall_cnt (16) and perf_bubble_cnt (16).
  - Counters increment in RUN on stall cycles and on cycles loading a bubble (redirect or wait state), respectively.
  - Both counters saturate at 0xFFFF and clear on reset.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg holds:
  - OPCODE_W=3, REG_ADDR_W=4.
  - OP_JR=3'b111.
  - NOP_INSTR (all zeros).
  - fetch_state_t enum {BOOT, RUN}.
- One sub-module: if_id_reg, the IF/ID register with hold (stall), flush (redirect/wait bubble), load (accept) and the opcode masking.
- PC logic and FSM stay in fetch_stage.

Test Plan:
- Reset then imem_ready=1 constant, memory returns 16'h1000+addr:
  - imem_req rises 1 cycle after reset release.
  - if_id_pc sequence 0,1,2,3 on consecutive cycles, if_id_valid=1.
- Stall for 3 cycles at pc=5:
  - if_id_pc holds 4, pc holds 5, imem_addr=5 throughout.
  - After release, if_id_pc=5 next cycle, with no skipped or duplicated word.
- redirect_valid with redirect_pc=0x40, asserted concurrently with stall=1:
  - Next cycle if_id_valid=0, id_opcode=0, imem_addr=0x40.
  - Following cycle if_id_pc=0x40.
- imem_ready low 2 cycles at pc=9: two bubbles inserted (if_id_valid=0), then if_id_pc=9.
- PC at 0xFF with accept: if_id_pc=0xFF, then imem_addr=0x00.
- FETCH_PERF_CNT_EN build, 3 stall cycles + 2 wait cycles: perf_stall_cnt=3, perf_bubble_cnt=2; reset mid-run clears both to 0.
